// File: rtl/factory_machine_line_parser.sv
// Byte-level front end for the factory machine initializer.
// Turns one machine description per text line, e.g. "[.##.] (3) (1,3) {3,5,4,7}\n",
// into the one-cycle token strobes of the initializer's mach_* interface.
// Each accepted byte produces at most one registered token on the next cycle.
// Malformed input parks the parser in ERR. After MACHINE_COUNT complete lines
// it parks in DONE. Both are left only by reset.
module factory_machine_line_parser #(
  parameter int MAX_LIGHT_COUNT  = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int MACHINE_COUNT    = 2,
  localparam int LCW = $clog2(MAX_LIGHT_COUNT + 1),
  localparam int BCW = $clog2(MAX_BUTTON_COUNT + 1),
  localparam int MCW = $clog2(MACHINE_COUNT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           mach_light_off,
  output logic           mach_light_on,
  output logic [3:0]     mach_button_index,
  output logic           mach_next_button,
  output logic           mach_buttons_end,
  output logic           mach_entry_end,
  output logic           mach_in_valid,
  output logic [MCW-1:0] machines_parsed,
  output logic           parse_done,
  output logic           parse_error
);

  // Parser states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LIGHTS = 3'd1;
  localparam logic [2:0] ST_SEP    = 3'd2;
  localparam logic [2:0] ST_BUTTON = 3'd3;
  localparam logic [2:0] ST_JOLT   = 3'd4;
  localparam logic [2:0] ST_EOL    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // ASCII bytes the grammar cares about
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_LBRK   = 8'h5B;
  localparam logic [7:0] CH_RBRK   = 8'h5D;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;

  // Counter limits in the counters' own widths
  localparam logic [LCW-1:0] LIGHT_MAX   = LCW'(MAX_LIGHT_COUNT);
  localparam logic [BCW-1:0] BUTTON_MAX  = BCW'(MAX_BUTTON_COUNT);
  localparam logic [MCW-1:0] MACHINE_MAX = MCW'(MACHINE_COUNT);
  localparam logic [4:0]     DIGIT_LIMIT = 5'(MAX_LIGHT_COUNT);

  // Saturating increments: the grammar checks report overflow first,
  // so saturation only guards against a wrap that should never be reached.
  function automatic logic [LCW-1:0] sat_inc_light(input logic [LCW-1:0] v);
    return (v == {LCW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [BCW-1:0] sat_inc_button(input logic [BCW-1:0] v);
    return (v == {BCW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [MCW-1:0] sat_inc_machine(input logic [MCW-1:0] v);
    return (v == {MCW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [LCW-1:0] light_cnt;
  logic [LCW-1:0] light_cnt_nx;
  logic [BCW-1:0] btn_cnt;
  logic [BCW-1:0] btn_cnt_nx;
  logic [MCW-1:0] mach_cnt_nx;
  logic           last_was_digit;
  logic           last_was_digit_nx;
  logic           done_nx;
  logic           error_nx;

  // Stage p0: byte accept and decode
  logic           accept_p0;
  logic           is_ignored_p0;
  logic           is_digit_p0;
  logic [3:0]     digit_p0;
  logic           tok_off_p0;
  logic           tok_on_p0;
  logic           tok_next_p0;
  logic           tok_bend_p0;
  logic           tok_eend_p0;
  logic [3:0]     tok_idx_p0;
  logic           vld_p0;

  // Stage p1: registered token presented to the initializer
  logic           tok_off_p1;
  logic           tok_on_p1;
  logic           tok_next_p1;
  logic           tok_bend_p1;
  logic           tok_eend_p1;
  logic [3:0]     tok_idx_p1;
  logic           vld_p1;

  assign in_ready      = ~parse_done;
  assign accept_p0     = in_valid & in_ready;
  assign is_ignored_p0 = (in_data == CH_SPACE) || (in_data == CH_CR);
  assign is_digit_p0   = (in_data >= CH_ZERO) && (in_data <= CH_NINE);
  assign digit_p0      = in_data[3:0];

  // Grammar FSM: next state, counter updates and the token for the accepted byte
  always_comb begin
    state_nx          = state;
    light_cnt_nx      = light_cnt;
    btn_cnt_nx        = btn_cnt;
    mach_cnt_nx       = machines_parsed;
    last_was_digit_nx = last_was_digit;
    done_nx           = parse_done;
    tok_off_p0        = 1'b0;
    tok_on_p0         = 1'b0;
    tok_next_p0       = 1'b0;
    tok_bend_p0       = 1'b0;
    tok_eend_p0       = 1'b0;
    tok_idx_p0        = 4'd0;
    vld_p0            = 1'b0;

    if (accept_p0) begin
      case (state)
        ST_IDLE: begin
          if (in_data == CH_LBRK) begin
            state_nx     = ST_LIGHTS;
            light_cnt_nx = '0;
            btn_cnt_nx   = '0;
          end else if (!(is_ignored_p0 || in_data == CH_LF)) begin
            state_nx = ST_ERR;
          end
        end

        ST_LIGHTS: begin
          if (in_data == CH_DOT || in_data == CH_HASH) begin
            if (light_cnt == LIGHT_MAX) begin
              state_nx = ST_ERR;
            end else begin
              tok_off_p0   = (in_data == CH_DOT);
              tok_on_p0    = (in_data == CH_HASH);
              vld_p0       = 1'b1;
              light_cnt_nx = sat_inc_light(light_cnt);
            end
          end else if (in_data == CH_RBRK && light_cnt != '0) begin
            state_nx = ST_SEP;
          end else begin
            // Covers an empty "[]" and any foreign byte, including blanks.
            state_nx = ST_ERR;
          end
        end

        ST_SEP: begin
          if (in_data == CH_LPAREN) begin
            state_nx          = ST_BUTTON;
            last_was_digit_nx = 1'b0;
          end else if (in_data == CH_LBRACE && btn_cnt != '0) begin
            state_nx    = ST_JOLT;
            tok_bend_p0 = 1'b1;
            vld_p0      = 1'b1;
          end else if (!is_ignored_p0) begin
            state_nx = ST_ERR;
          end
        end

        ST_BUTTON: begin
          if (is_digit_p0) begin
            // Indices are single digits; a second digit in a row is a multi-digit index.
            if (last_was_digit || ({1'b0, digit_p0} >= DIGIT_LIMIT)) begin
              state_nx = ST_ERR;
            end else begin
              tok_idx_p0        = digit_p0;
              vld_p0            = 1'b1;
              last_was_digit_nx = 1'b1;
            end
          end else if (in_data == CH_COMMA) begin
            last_was_digit_nx = 1'b0;
          end else if (in_data == CH_RPAREN) begin
            if (btn_cnt == BUTTON_MAX) begin
              state_nx = ST_ERR;
            end else begin
              tok_next_p0 = 1'b1;
              vld_p0      = 1'b1;
              btn_cnt_nx  = sat_inc_button(btn_cnt);
              state_nx    = ST_SEP;
            end
          end else if (!is_ignored_p0) begin
            state_nx = ST_ERR;
          end
        end

        ST_JOLT: begin
          // Joltage targets are not needed by the initializer; only the syntax is checked.
          if (in_data == CH_RBRACE) begin
            state_nx = ST_EOL;
          end else if (!(is_digit_p0 || in_data == CH_COMMA || is_ignored_p0)) begin
            state_nx = ST_ERR;
          end
        end

        ST_EOL: begin
          if (in_data == CH_LF) begin
            tok_eend_p0 = 1'b1;
            vld_p0      = 1'b1;
            mach_cnt_nx = sat_inc_machine(machines_parsed);
            if (mach_cnt_nx == MACHINE_MAX) begin
              state_nx = ST_DONE;
              done_nx  = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end else if (!is_ignored_p0) begin
            state_nx = ST_ERR;
          end
        end

        ST_DONE: state_nx = ST_DONE;
        ST_ERR:  state_nx = ST_ERR;
        default: state_nx = ST_ERR;
      endcase
    end

    error_nx = parse_error | (state_nx == ST_ERR);
  end

  // Control state: FSM, counters and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      light_cnt       <= '0;
      btn_cnt         <= '0;
      machines_parsed <= '0;
      last_was_digit  <= 1'b0;
      parse_done      <= 1'b0;
      parse_error     <= 1'b0;
    end else begin
      state           <= state_nx;
      light_cnt       <= light_cnt_nx;
      btn_cnt         <= btn_cnt_nx;
      machines_parsed <= mach_cnt_nx;
      last_was_digit  <= last_was_digit_nx;
      parse_done      <= done_nx;
      parse_error     <= error_nx;
    end
  end

  // Stage p0 -> p1: register the token; reset clears it so nothing stale leaks out
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_off_p1  <= 1'b0;
      tok_on_p1   <= 1'b0;
      tok_next_p1 <= 1'b0;
      tok_bend_p1 <= 1'b0;
      tok_eend_p1 <= 1'b0;
      tok_idx_p1  <= 4'd0;
      vld_p1      <= 1'b0;
    end else begin
      tok_off_p1  <= tok_off_p0;
      tok_on_p1   <= tok_on_p0;
      tok_next_p1 <= tok_next_p0;
      tok_bend_p1 <= tok_bend_p0;
      tok_eend_p1 <= tok_eend_p0;
      tok_idx_p1  <= tok_idx_p0;
      vld_p1      <= vld_p0;
    end
  end

  assign mach_light_off    = tok_off_p1;
  assign mach_light_on     = tok_on_p1;
  assign mach_next_button  = tok_next_p1;
  assign mach_buttons_end  = tok_bend_p1;
  assign mach_entry_end    = tok_eend_p1;
  assign mach_button_index = tok_idx_p1;
  assign mach_in_valid     = vld_p1;

endmodule

// File: tb/tb_factory_machine_line_parser.sv
// Bench for factory_machine_line_parser. Two instances:
//   a: MAX_LIGHT_COUNT=10, MACHINE_COUNT=2
//   b: MAX_LIGHT_COUNT=4,  MACHINE_COUNT=1
// Expected tokens are queued as characters before a line is driven:
//   'o' light off, 'h' light on, '0'..'9' index, 'n' next button,
//   'b' buttons end, 'e' entry end.
// A negedge monitor pops and compares each token the DUTs emit.
module tb_factory_machine_line_parser;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_off, a_on, a_next, a_bend, a_eend, a_mvld;
  logic       b_off, b_on, b_next, b_bend, b_eend, b_mvld;
  logic [3:0] a_idx, b_idx;
  logic [1:0] a_parsed;
  logic [0:0] b_parsed;
  logic       a_done, a_err, b_done, b_err;

  int checks   = 0;
  int failures = 0;

  byte qa[$];
  byte qb[$];

  always #5 clk = ~clk;

  factory_machine_line_parser #(
    .MAX_LIGHT_COUNT(10), .MAX_BUTTON_COUNT(13), .MACHINE_COUNT(2)
  ) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mach_light_off(a_off), .mach_light_on(a_on), .mach_button_index(a_idx),
    .mach_next_button(a_next), .mach_buttons_end(a_bend), .mach_entry_end(a_eend),
    .mach_in_valid(a_mvld), .machines_parsed(a_parsed), .parse_done(a_done),
    .parse_error(a_err)
  );

  factory_machine_line_parser #(
    .MAX_LIGHT_COUNT(4), .MAX_BUTTON_COUNT(13), .MACHINE_COUNT(1)
  ) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mach_light_off(b_off), .mach_light_on(b_on), .mach_button_index(b_idx),
    .mach_next_button(b_next), .mach_buttons_end(b_bend), .mach_entry_end(b_eend),
    .mach_in_valid(b_mvld), .machines_parsed(b_parsed), .parse_done(b_done),
    .parse_error(b_err)
  );

  // Decode a token into its character; '?' when the flags are not a legal encoding.
  function automatic byte tok_char(input logic off, input logic on, input logic nxt,
                                   input logic bend, input logic eend, input logic [3:0] idx);
    case ({off, on, nxt, bend, eend})
      5'b10000: return "o";
      5'b01000: return "h";
      5'b00100: return "n";
      5'b00010: return "b";
      5'b00001: return "e";
      5'b00000: return (idx <= 4'd9) ? byte'(8'h30 + {4'd0, idx}) : "?";
      default:  return "?";
    endcase
  endfunction

  // Scoreboard: every strobe must match the next queued token; idle cycles must be all-zero.
  always @(negedge clk) begin
    byte got;
    byte exp;
    if (a_mvld) begin
      got = tok_char(a_off, a_on, a_next, a_bend, a_eend, a_idx);
      exp = (qa.size() == 0) ? "!" : qa.pop_front();
      checks++;
      assert (got === exp) else begin
        failures++;
        $error("FAIL tok_a got=%s exp=%s", got, exp);
      end
    end else begin
      checks++;
      assert ({a_off, a_on, a_next, a_bend, a_eend} === 5'b0) else begin
        failures++;
        $error("FAIL idle_a flags=%b exp=00000", {a_off, a_on, a_next, a_bend, a_eend});
      end
    end
    if (b_mvld) begin
      got = tok_char(b_off, b_on, b_next, b_bend, b_eend, b_idx);
      exp = (qb.size() == 0) ? "!" : qb.pop_front();
      checks++;
      assert (got === exp) else begin
        failures++;
        $error("FAIL tok_b got=%s exp=%s", got, exp);
      end
    end else begin
      checks++;
      assert ({b_off, b_on, b_next, b_bend, b_eend} === 5'b0) else begin
        failures++;
        $error("FAIL idle_b flags=%b exp=00000", {b_off, b_on, b_next, b_bend, b_eend});
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string s);
    for (int i = 0; i < s.len(); i++) qa.push_back(s[i]);
  endtask

  task automatic expect_b(input string s);
    for (int i = 0; i < s.len(); i++) qb.push_back(s[i]);
  endtask

  // One byte per cycle, or one byte every other cycle when gap is set.
  task automatic send_a(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); a_valid = 1'b1; a_data = s[i];
      if (gap) begin @(negedge clk); a_valid = 1'b0; end
    end
    @(negedge clk); a_valid = 1'b0;
  endtask

  task automatic send_b(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); b_valid = 1'b1; b_data = s[i];
    end
    @(negedge clk); b_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_qa_empty"}, qa.size(), 0);
    check({tag, "_qb_empty"}, qb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h0; b_data = 8'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_parsed", int'(a_parsed), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_err", int'(a_err), 0);
    check("rst_ready", int'(a_ready), 1);
    check("rst_mvld", int'(a_mvld), 0);

    // Single-machine line, gapless, on b
    expect_b("ohho3n13nbe");
    send_b("[.##.] (3) (1,3) {3,5}\n");
    drain("t1");
    check("t1_parsed", int'(b_parsed), 1);
    check("t1_done", int'(b_done), 1);
    check("t1_ready", int'(b_ready), 0);
    check("t1_err", int'(b_err), 0);

    // Two machines on a, every other cycle, blank line between
    expect_a("ohho3n13nbe");
    send_a("[.##.] (3) (1,3) {3,5,4,7}\n", 1'b1);
    drain("t2a");
    check("t2_parsed1", int'(a_parsed), 1);
    check("t2_done1", int'(a_done), 0);
    expect_a("ho01nnbe");
    send_a("\n[#.] (0,1) () {2}\n", 1'b1);
    drain("t2b");
    check("t2_parsed2", int'(a_parsed), 2);
    check("t2_done2", int'(a_done), 1);
    check("t2_ready", int'(a_ready), 0);
    check("t2_err", int'(a_err), 0);

    // Two-digit index is an error; later bytes are accepted and dropped
    do_reset();
    check("t3_rst_parsed", int'(a_parsed), 0);
    expect_a("h1");
    send_a("[#] (12)", 1'b0);
    drain("t3a");
    check("t3_err", int'(a_err), 1);
    check("t3_ready", int'(a_ready), 1);
    send_a("[.] (3) {1}\n", 1'b0);
    drain("t3b");
    check("t3_err_sticky", int'(a_err), 1);
    check("t3_parsed", int'(a_parsed), 0);

    // Light overflow with MAX_LIGHT_COUNT=4
    do_reset();
    expect_b("oooo");
    send_b("[.....");
    drain("t4a");
    check("t4a_err", int'(b_err), 1);

    // Index equal to MAX_LIGHT_COUNT
    do_reset();
    expect_b("o");
    send_b("[.] (4)");
    drain("t4b");
    check("t4b_err", int'(b_err), 1);

    // Buttons-end with no buttons
    do_reset();
    expect_a("o");
    send_a("[.] {1}\n", 1'b0);
    drain("t5a");
    check("t5a_err", int'(a_err), 1);

    // Empty light list
    do_reset();
    send_a("[]", 1'b0);
    drain("t5b");
    check("t5b_err", int'(a_err), 1);

    // Reset in the middle of a line, then a full line
    do_reset();
    check("t6_rst_err", int'(a_err), 0);
    expect_a("oh0");
    send_a("[.#] (0", 1'b0);
    do_reset();
    check("t6_mid_parsed", int'(a_parsed), 0);
    expect_a("ho1nbe");
    send_a("[#.] (1) {9}\n", 1'b0);
    drain("t6");
    check("t6_parsed", int'(a_parsed), 1);
    check("t6_done", int'(a_done), 0);
    check("t6_err", int'(a_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
